demux_serial_adder: RTL and testbench

// - Bit-serial WIDTH-bit adder; one full-adder step per clock.
// - The step is a 1-to-8 demux of a constant '1', selected by {a_bit, b_bit, carry}:
//   - sum   = OR of minterms 1, 2, 4, 7
//   - carry = OR of minterms 3, 5, 6, 7
// - Parametrised, sequential successor to the combinational demux full adder.
// - Used where area matters more than latency; start/busy/done handshake to the requester.

---
 rtl/demux_serial_adder.sv | 165 ++++++++++++++++
 tb/tb_demux_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : demux_serial_adder
// Purpose  : Bit-serial WIDTH-bit adder performing one full-adder step per
//            clock. Each step drives a 1-to-8 demux of a constant '1' with
//            select {a_bit, b_bit, carry}. The sum bit is the OR of minterms
//            1, 2, 4 and 7. The next carry is the OR of minterms 3, 5, 6
//            and 7. A start/busy/done handshake connects it to the
//            requester.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous reset, active-high
//            start    - request, sampled only when not busy
//            a, b     - WIDTH-bit operands, latched on an accepted start
//            cin      - carry-in, latched on an accepted start
//            sub      - (DEMUX_ADDER_SUB_EN only) 1 = compute a - b
//            busy     - operation in progress
//            done     - one-cycle pulse, sum/cout valid
//            sum      - WIDTH-bit result, held until the next completion
//            cout     - carry-out (no-borrow when subtracting), held with sum
//            dec_out  - one-hot demux minterm of the current step, 0 otherwise
// Config   : `define DEMUX_ADDER_SUB_EN adds the sub port (a - b).
// Revision : 1.0 - initial release
// ============================================================================
module demux_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DEMUX_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [7:0]       dec_out
);

    localparam int              C_CW            = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST_STEP     = C_CW'(WIDTH - 1);
    // Minterm masks: bit k set means minterm k contributes to the output.
    localparam logic [7:0]      C_SUM_TERMS     = 8'b1001_0110;  // 1,2,4,7
    localparam logic [7:0]      C_CARRY_TERMS   = 8'b1110_1000;  // 3,5,6,7

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // r_a doubles as the result shift register: every step consumes its LSB
    // and pushes the new sum bit in at the MSB, so after WIDTH steps it holds
    // the complete result with no separate storage.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [C_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [WIDTH-1:0]  w_b_in;
    logic              w_carry_init;
    logic [2:0]        w_sel;
    logic [7:0]        w_minterm;
    logic              w_sum_bit;
    logic              w_carry_bit;
    logic              w_accept;
    logic              w_last;
    logic [WIDTH-1:0]  w_res_next;

    // Subtraction is a + ~b + 1; the operand is stored already inverted so
    // the step logic is identical for both operations.
`ifdef DEMUX_ADDER_SUB_EN
    assign w_b_in       = sub ? ~b : b;
    assign w_carry_init = sub ? 1'b1 : cin;
`else
    assign w_b_in       = b;
    assign w_carry_init = cin;
`endif

    assign w_sel       = {r_a[0], r_b[0], r_carry};
    assign w_minterm   = 8'd1 << w_sel;
    assign w_sum_bit   = |(w_minterm & C_SUM_TERMS);
    assign w_carry_bit = |(w_minterm & C_CARRY_TERMS);
    assign w_res_next  = {w_sum_bit, r_a[WIDTH-1:1]};
    assign w_last      = (r_cnt == C_LAST_STEP);

    // A new request is taken in IDLE and also in DONE, which gives
    // back-to-back operation without an idle bubble.
    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= w_b_in;
                r_carry <= w_carry_init;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= w_res_next;
                r_b     <= {1'b0, r_b[WIDTH-1:1]};
                r_carry <= w_carry_bit;
                r_cnt   <= r_cnt + 1'b1;
                // Published results change only on the completing edge.
                if (w_last) begin
                    r_sum  <= w_res_next;
                    r_cout <= w_carry_bit;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and demux output
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        dec_out      = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                dec_out = w_minterm;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_demux_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_serial_adder
// Purpose  : Self-checking bench for demux_serial_adder (WIDTH = 8). The
//            reference model computes expected results with plain integer
//            arithmetic, and expected demux minterms from operand bits.
//            The bench also covers the DEMUX_ADDER_SUB_EN build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_serial_adder;

    localparam int W = 8;
`ifdef DEMUX_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
`ifdef DEMUX_ADDER_SUB_EN
    logic          sub;
`endif
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic [7:0]    dec_out;

    int            n_assert = 0;
    int            n_fail   = 0;

    // Reference model state
    logic [W-1:0]  m_a;
    logic [W-1:0]  m_b;
    logic          m_c;
    logic [W:0]    m_exp;
    logic [W-1:0]  m_sum_prev;
    logic          m_cout_prev;

    always #5 clk = ~clk;

    demux_serial_adder #(
        .WIDTH   (W)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef DEMUX_ADDER_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .dec_out (dec_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge after the
    // accepting edge with the inputs scrambled.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        logic u;
        u     = SUB_EN & ts;
        a     = ta;
        b     = tb;
        cin   = tc;
`ifdef DEMUX_ADDER_SUB_EN
        sub   = ts;
`endif
        start = 1'b1;
        m_a   = ta;
        m_b   = u ? ~tb : tb;
        m_c   = u ? 1'b1 : tc;
        m_exp = {1'b0, ta} + {1'b0, m_b} + {{W{1'b0}}, m_c};
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
`ifdef DEMUX_ADDER_SUB_EN
        sub   = 1'($urandom);
`endif
    endtask

    // Check one serial step against the arithmetic model.
    task automatic step(input int i);
        int         sel;
        logic [7:0] e_dec;
        sel   = int'(m_a[i]) * 4 + int'(m_b[i]) * 2 + int'(m_c);
        e_dec = 8'd1 << sel;
        chk("dec_out", 64'(dec_out), 64'(e_dec));
        chk("busy_run", 64'(busy), 64'd1);
        chk("done_run", 64'(done), 64'd0);
        chk("sum_held", 64'(sum), 64'(m_sum_prev));
        chk("cout_held", 64'(cout), 64'(m_cout_prev));
        m_c = (int'(m_a[i]) + int'(m_b[i]) + int'(m_c)) >= 2;
    endtask

    // All WIDTH steps, then the done cycle. poke >= 0 raises start during
    // that step to check that a request while busy is ignored.
    task automatic run_steps(input int poke);
        for (int i = 0; i < W; i++) begin
            step(i);
            if (i == poke) begin
                start = 1'b1;
                a     = 8'hF0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("dec_done", 64'(dec_out), 64'd0);
        chk("sum", 64'(sum), 64'(m_exp[W-1:0]));
        chk("cout", 64'(cout), 64'(m_exp[W]));
        m_sum_prev  = m_exp[W-1:0];
        m_cout_prev = m_exp[W];
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("dec_idle", 64'(dec_out), 64'd0);
        chk("sum_idle", 64'(sum), 64'(m_sum_prev));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
`ifdef DEMUX_ADDER_SUB_EN
        sub         = 1'b0;
`endif
        m_sum_prev  = '0;
        m_cout_prev = 1'b0;
        m_a         = '0;
        m_b         = '0;
        m_c         = 1'b0;
        m_exp       = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_dec", 64'(dec_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        issue(8'h3C, 8'h05, 1'b0, 1'b0);
        run_steps(-1);
        chk("sum_3c05", 64'(sum), 64'h41);
        chk("cout_3c05", 64'(cout), 64'd0);
        idle_check();

        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        run_steps(-1);
        chk("sum_ff01", 64'(sum), 64'h00);
        chk("cout_ff01", 64'(cout), 64'd1);
        idle_check();

        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_steps(-1);
        chk("sum_ffff1", 64'(sum), 64'hFF);
        chk("cout_ffff1", 64'(cout), 64'd1);
        idle_check();

        // Start while busy is ignored
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        run_steps(2);
        chk("sum_ignore", 64'(sum), 64'h02);
        idle_check();

        // Reset in the middle of an operation
        issue(8'hA5, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i);
            if (i == 3) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_dec", 64'(dec_out), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        m_sum_prev  = '0;
        m_cout_prev = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", 64'(done), 64'd0);
        end

        issue(8'h10, 8'h20, 1'b0, 1'b0);
        run_steps(-1);
        chk("sum_1020", 64'(sum), 64'h30);
        idle_check();

`ifdef DEMUX_ADDER_SUB_EN
        issue(8'h05, 8'h07, 1'b0, 1'b1);
        run_steps(-1);
        chk("sub_sum_5m7", 64'(sum), 64'hFE);
        chk("sub_cout_5m7", 64'(cout), 64'd0);
        idle_check();

        issue(8'h07, 8'h05, 1'b1, 1'b1);
        run_steps(-1);
        chk("sub_sum_7m5", 64'(sum), 64'h02);
        chk("sub_cout_7m5", 64'(cout), 64'd1);
        idle_check();
`endif

        // Back-to-back: new request presented in the done cycle
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        run_steps(-1);
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        run_steps(-1);
        idle_check();

        // Randomized operations, mixing idle gaps and back-to-back chains
        for (int n = 0; n < 30; n++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            run_steps(-1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
